// File: rtl/cache_control.sv
// Cache controller FSM: hit/miss resolution, dirty writeback, line allocate and re-read.
// Define CACHE_PERF_CNT_EN to build the saturating hit/miss performance counters.
module cache_control #(
   parameter int unsigned S_OFFSET = 5,
   parameter int unsigned S_MASK   = 2**S_OFFSET
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [S_MASK-1:0] mem_byte_enable_line,
   input  logic              hit,
   input  logic              dirty,
   input  logic              pmem_resp,
   output logic              mem_resp,
   output logic              array_read,
   output logic [S_MASK-1:0] array_write_en,
   output logic              datain_sel,
   output logic              tag_load,
   output logic              valid_load,
   output logic              dirty_load,
   output logic              dirty_in,
   output logic              pmem_addr_sel,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   typedef enum logic [2:0] {
      StIdle,
      StCompare,
      StWriteback,
      StAllocate,
      StReread
   } state_e;

   state_e state_q, state_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      mem_resp       = 1'b0;
      array_read     = 1'b0;
      array_write_en = '0;
      datain_sel     = 1'b0;
      tag_load       = 1'b0;
      valid_load     = 1'b0;
      dirty_load     = 1'b0;
      dirty_in       = 1'b0;
      pmem_addr_sel  = 1'b0;
      pmem_read      = 1'b0;
      pmem_write     = 1'b0;
      // Outputs are forced low while reset is held, even if a CPU request is still asserted.
      if (rst_n) begin
         unique case (state_q)
            StIdle: begin
               if (mem_read || mem_write) begin
                  array_read = 1'b1;
                  state_d    = StCompare;
               end
            end
            StCompare: begin
               if (hit) begin
                  mem_resp = 1'b1;
                  // A simultaneous read and write is served as a write.
                  if (mem_write) begin
                     array_write_en = mem_byte_enable_line;
                     datain_sel     = 1'b0;
                     dirty_load     = 1'b1;
                     dirty_in       = 1'b1;
                  end
                  state_d = StIdle;
               end else begin
                  state_d = dirty ? StWriteback : StAllocate;
               end
            end
            StWriteback: begin
               pmem_write    = 1'b1;
               pmem_addr_sel = 1'b1;
               if (pmem_resp) begin
                  state_d = StAllocate;
               end
            end
            StAllocate: begin
               pmem_read     = 1'b1;
               pmem_addr_sel = 1'b0;
               if (pmem_resp) begin
                  array_write_en = '1;
                  datain_sel     = 1'b1;
                  tag_load       = 1'b1;
                  valid_load     = 1'b1;
                  dirty_load     = 1'b1;
                  dirty_in       = 1'b0;
                  state_d        = StReread;
               end
            end
            StReread: begin
               array_read = 1'b1;
               state_d    = StCompare;
            end
            default: state_d = StIdle;
         endcase
      end
   end

`ifdef CACHE_PERF_CNT_EN
   logic        first_q;
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   // first_q marks a COMPARE reached from IDLE; COMPAREs after a re-read are not counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q    <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (state_q == StIdle) begin
            first_q <= 1'b1;
         end else if (state_q == StReread) begin
            first_q <= 1'b0;
         end
         if (state_q == StCompare && first_q) begin
            if (hit) begin
               if (hit_cnt_q != 32'hFFFF_FFFF) begin
                  hit_cnt_q <= hit_cnt_q + 32'd1;
               end
            end else if (miss_cnt_q != 32'hFFFF_FFFF) begin
               miss_cnt_q <= miss_cnt_q + 32'd1;
            end
         end
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Randomized scoreboard bench for cache_control: stimulus pushes expected responses,
// a negedge monitor pops and compares them on every mem_resp.
module tb_cache_control;

   logic        clk;
   logic        rst_n;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_byte_enable_line;
   logic        hit;
   logic        dirty;
   logic        pmem_resp;
   logic        mem_resp;
   logic        array_read;
   logic [31:0] array_write_en;
   logic        datain_sel;
   logic        tag_load;
   logic        valid_load;
   logic        dirty_load;
   logic        dirty_in;
   logic        pmem_addr_sel;
   logic        pmem_read;
   logic        pmem_write;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   cache_control dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .mem_read             (mem_read),
      .mem_write            (mem_write),
      .mem_byte_enable_line (mem_byte_enable_line),
      .hit                  (hit),
      .dirty                (dirty),
      .pmem_resp            (pmem_resp),
      .mem_resp             (mem_resp),
      .array_read           (array_read),
      .array_write_en       (array_write_en),
      .datain_sel           (datain_sel),
      .tag_load             (tag_load),
      .valid_load           (valid_load),
      .dirty_load           (dirty_load),
      .dirty_in             (dirty_in),
      .pmem_addr_sel        (pmem_addr_sel),
      .pmem_read            (pmem_read),
      .pmem_write           (pmem_write),
      .hit_count            (hit_count),
      .miss_count           (miss_count)
   );

   typedef struct {
      bit          is_write;
      logic [31:0] mask;
      bit          was_hit;
      int          req_cyc;
      int          lat;
      int          exp_w;
      int          exp_r;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          cur_w = 1;
   int          cur_l = 1;
   int          wcnt = 0;
   int          rcnt = 0;
   int          rc = 0;
   int          wc = 0;
   bit          txn_hit = 1'b0;
   bit          txn_dirty = 1'b0;
   bit          refilled = 1'b0;
   bit          done_flag = 1'b0;
   bit          cnt_pending = 1'b0;
   logic [31:0] m_hits = '0;
   logic [31:0] m_miss = '0;
   logic [31:0] exp_we;

   // Memory-side environment: the refilled line always hits on its re-read.
   assign hit   = txn_hit | refilled;
   assign dirty = txn_dirty;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Physical memory responder: pmem_resp after cur_w write cycles / cur_l read cycles.
   always begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
         pmem_resp = 1'b0;
         wcnt      = 0;
         rcnt      = 0;
      end else if (pmem_write) begin
         wcnt++;
         pmem_resp = (wcnt == cur_w);
      end else if (pmem_read) begin
         rcnt++;
         pmem_resp = (rcnt == cur_l);
         if (rcnt == cur_l) refilled = 1'b1;
      end else begin
         wcnt      = 0;
         rcnt      = 0;
         pmem_resp = ($urandom_range(0, 3) == 0);
      end
   end

   // Monitor / scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         rc          = 0;
         wc          = 0;
         cnt_pending = 1'b0;
         m_hits      = '0;
         m_miss      = '0;
      end else begin
         if (pmem_read) rc++;
         if (pmem_write) wc++;
         if (cnt_pending) begin
            chk("hit_count", hit_count, m_hits);
            chk("miss_count", miss_count, m_miss);
            cnt_pending = 1'b0;
         end
         if (exp_q.size() > 0 && cyc == exp_q[0].req_cyc) begin
            chk("array_read_on_request", 32'(array_read), 32'd1);
         end
         exp_we = (pmem_read && pmem_resp) ? 32'hFFFF_FFFF : 32'h0;
         if (pmem_read && pmem_resp) begin
            chk("refill_controls", {27'd0, tag_load, valid_load, dirty_load, datain_sel, dirty_in},
                32'b11110);
         end
         if (pmem_write) chk("wb_addr_sel", 32'(pmem_addr_sel), 32'd1);
         if (pmem_read) chk("alloc_addr_sel", 32'(pmem_addr_sel), 32'd0);
         chk("pmem_rd_wr_exclusive", 32'(pmem_read & pmem_write), 32'd0);
         if (mem_resp) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_mem_resp", 32'(mem_resp), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("latency", 32'(cyc - mon_e.req_cyc), 32'(mon_e.lat));
               chk("pmem_read_cycles", 32'(rc), 32'(mon_e.exp_r));
               chk("pmem_write_cycles", 32'(wc), 32'(mon_e.exp_w));
               if (mon_e.is_write) begin
                  exp_we = mon_e.mask;
                  chk("write_hit_ctrl", {29'd0, dirty_load, dirty_in, datain_sel}, 32'b110);
               end else begin
                  chk("read_hit_dirty_load", 32'(dirty_load), 32'd0);
               end
`ifdef CACHE_PERF_CNT_EN
               if (mon_e.was_hit) begin
                  if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 32'd1;
               end else if (m_miss != 32'hFFFF_FFFF) begin
                  m_miss = m_miss + 32'd1;
               end
`endif
               rc          = 0;
               wc          = 0;
               done_flag   = 1'b1;
               cnt_pending = 1'b1;
            end
         end
         chk("array_write_en", array_write_en, exp_we);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_txn(input bit rd, input bit wr, input logic [31:0] m, input bit h,
                         input bit d, input int w, input int l);
      exp_t e;
      txn_hit   = h;
      txn_dirty = d;
      refilled  = 1'b0;
      cur_w     = w;
      cur_l     = l;
      done_flag = 1'b0;
      e.is_write = wr;
      e.mask     = m;
      e.was_hit  = h;
      e.req_cyc  = cyc;
      e.lat      = h ? 1 : 1 + (d ? w : 0) + l + 2;
      e.exp_w    = (!h && d) ? w : 0;
      e.exp_r    = h ? 0 : l;
      exp_q.push_back(e);
      mem_read             = rd;
      mem_write            = wr;
      mem_byte_enable_line = m;
      for (int k = 0; k < 300 && !done_flag; k++) tick();
      chk("txn_completed", 32'(done_flag), 32'd1);
      if (!done_flag) exp_q.delete();
      mem_read             = 1'b0;
      mem_write            = 1'b0;
      mem_byte_enable_line = $urandom;
   endtask

   initial begin
      int op;
      rst_n                = 1'b0;
      mem_read             = 1'b0;
      mem_write            = 1'b0;
      mem_byte_enable_line = '0;
      pmem_resp            = 1'b0;
      #3;
      chk("reset_outputs", {22'd0, mem_resp, array_read, datain_sel, tag_load, valid_load,
                            dirty_load, dirty_in, pmem_addr_sel, pmem_read, pmem_write}, 32'd0);
      chk("reset_we", array_write_en, 32'd0);
      chk("reset_hit_count", hit_count, 32'd0);
      chk("reset_miss_count", miss_count, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();

      do_txn(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1, 1);                // read hit
      tick();
      do_txn(1'b0, 1'b1, 32'h0000_000F, 1'b1, 1'b0, 1, 1);        // write hit
      tick();
      do_txn(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1, 3);                // clean miss
      tick();
      do_txn(1'b0, 1'b1, 32'hF0F0_0001, 1'b0, 1'b1, 2, 3);        // dirty miss
      tick();
      do_txn(1'b1, 1'b1, 32'h00FF_0000, 1'b1, 1'b1, 1, 1);        // read+write -> write

      for (int i = 0; i < 60; i++) begin
         op = int'($urandom_range(1, 3));
         do_txn(op[0], op[1], $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
         for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
      end

      // Reset in the middle of an allocate: no response may follow.
      tick();
      txn_hit   = 1'b0;
      txn_dirty = 1'b0;
      refilled  = 1'b0;
      cur_l     = 20;
      mem_read  = 1'b1;
      for (int k = 0; k < 10 && !pmem_read; k++) tick();
      chk("reached_allocate", 32'(pmem_read), 32'd1);
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_pmem_read", 32'(pmem_read), 32'd0);
      chk("rst_mem_resp", 32'(mem_resp), 32'd0);
      chk("rst_array_read", 32'(array_read), 32'd0);
      chk("rst_hit_count", hit_count, 32'd0);
      chk("rst_miss_count", miss_count, 32'd0);
      mem_read = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      chk("post_rst_pmem_read", 32'(pmem_read), 32'd0);

`ifdef CACHE_PERF_CNT_EN
      force dut.hit_cnt_q = 32'hFFFF_FFFF;
      tick();
      release dut.hit_cnt_q;
      m_hits = 32'hFFFF_FFFF;
      chk("hit_count_preload", hit_count, 32'hFFFF_FFFF);
      do_txn(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1, 1);
      tick();
      chk("hit_count_saturated", hit_count, 32'hFFFF_FFFF);
`else
      do_txn(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1, 1);
      tick();
      chk("hit_count_disabled", hit_count, 32'd0);
      chk("miss_count_disabled", miss_count, 32'd0);
`endif
      tick();
      tick();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
